// File: rtl/sfif_mrd_cpl_gen.sv
// sfif_mrd_cpl_gen: answers 32-bit MRd TLPs from a 64-bit RX stream with a CplD
// (or a no-data UR Cpl for oversize reads) on a 64-bit TX stream. Rev 1.0
`default_nettype none

module sfif_mrd_cpl_gen #(
  parameter int MAX_DW = 16,
  parameter int AW     = 10
) (
  input  logic          clk_125,
  input  logic          rst,
  input  logic [15:0]   completer_id,
  input  logic          rx64_st,
  input  logic          rx64_end,
  input  logic [63:0]   rx64_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [31:0]   mem_data,
  output logic          tx64_req,
  input  logic          tx64_rdy,
  output logic          tx64_val,
  output logic          tx64_st,
  output logic          tx64_end,
  output logic          tx64_dwen,
  output logic [63:0]   tx64_data,
  output logic          busy,
  output logic [15:0]   drop_cnt
);

  localparam int          BW      = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;
  localparam logic [10:0] MAX_LEN = 11'(MAX_DW);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR2  = 3'd1,
    S_FETCH = 3'd2,
    S_REQ   = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   len_q, len_d;
  logic [10:0]   cnt_q, cnt_d;
  logic          ur_q, ur_d;
  logic [15:0]   req_id_q, req_id_d;
  logic [7:0]    tag_q, tag_d;
  logic [AW-1:0] base_q, base_d;
  logic [4:0]    la_q, la_d;
  logic [6:0]    beat_q, beat_d;
  logic [15:0]   drop_q, drop_d;
  logic [31:0]   buf_q [2**BW];

  logic          w_mrd;
  logic          w_last;
  logic [10:0]   w_nbeats;
  logic [10:0]   w_hi_idx, w_lo_idx, w_wr_idx;
  logic [31:0]   w_dw0, w_dw1, w_dw2;
  logic [63:0]   w_beat_data;
  logic          unused_sink;

  assign w_mrd    = rx64_st && (rx64_data[63:56] == 8'h00);
  assign w_nbeats = ur_q ? 11'd2 : ((len_q + 11'd4) >> 1);
  assign w_last   = ({4'd0, beat_q} == (w_nbeats - 11'd1));
  assign w_hi_idx = {3'd0, beat_q, 1'b0} - 11'd3;
  assign w_lo_idx = {3'd0, beat_q, 1'b0} - 11'd2;
  assign w_wr_idx = cnt_q - 11'd1;

  // len_q[9:0] is the raw length field, so 1024 DW naturally encodes as 0
  assign w_dw0 = ur_q ? {8'h0A, 24'd0} : {8'h4A, 14'd0, len_q[9:0]};
  assign w_dw1 = {completer_id, (ur_q ? 3'b001 : 3'b000), 1'b0,
                  (ur_q ? 12'd0 : {len_q[9:0], 2'b00})};
  assign w_dw2 = {req_id_q, tag_q, 1'b0, la_q, 2'b00};

  always_comb begin
    w_beat_data = '0;
    if (beat_q == 7'd0) begin
      w_beat_data = {w_dw0, w_dw1};
    end else if (beat_q == 7'd1) begin
      w_beat_data = {w_dw2, (ur_q ? 32'd0 : buf_q[0])};
    end else begin
      w_beat_data[63:32] = buf_q[w_hi_idx[BW-1:0]];
      if (w_lo_idx < len_q) begin
        w_beat_data[31:0] = buf_q[w_lo_idx[BW-1:0]];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ur_d     = ur_q;
    req_id_d = req_id_q;
    tag_d    = tag_q;
    base_d   = base_q;
    la_d     = la_q;
    beat_d   = beat_q;
    drop_d   = drop_q;
    tx64_req = 1'b0;
    tx64_val = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_mrd) begin
          state_d  = S_HDR2;
          len_d    = (rx64_data[41:32] == 10'd0) ? 11'd1024 : {1'b0, rx64_data[41:32]};
          req_id_d = rx64_data[31:16];
          tag_d    = rx64_data[15:8];
        end
      end
      S_HDR2: begin
        base_d = rx64_data[AW+33:34];
        la_d   = rx64_data[38:34];
        cnt_d  = 11'd0;
        beat_d = 7'd0;
        ur_d   = (len_q > MAX_LEN);
        state_d = (len_q > MAX_LEN) ? S_REQ : S_FETCH;
      end
      S_FETCH: begin
        // one extra cycle after the last read lets its data land in the buffer
        if (cnt_q == len_q) begin
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_REQ: begin
        tx64_req = 1'b1;
        if (tx64_rdy) state_d = S_SEND;
      end
      S_SEND: begin
        tx64_req = 1'b1;
        tx64_val = 1'b1;
        if (tx64_rdy) begin
          if (w_last) begin
            state_d = S_IDLE;
            beat_d  = 7'd0;
          end else begin
            beat_d = beat_q + 7'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_mrd && (state_q == S_FETCH || state_q == S_REQ || state_q == S_SEND)
        && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      ur_q     <= 1'b0;
      req_id_q <= '0;
      tag_q    <= '0;
      base_q   <= '0;
      la_q     <= '0;
      beat_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ur_q     <= ur_d;
      req_id_q <= req_id_d;
      tag_q    <= tag_d;
      base_q   <= base_d;
      la_q     <= la_d;
      beat_q   <= beat_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_125) begin
    if (state_q == S_FETCH && cnt_q != 11'd0) begin
      buf_q[w_wr_idx[BW-1:0]] <= mem_data;
    end
  end

  assign mem_rd    = (state_q == S_FETCH) && (cnt_q < len_q);
  assign mem_addr  = mem_rd ? (base_q + AW'(cnt_q)) : '0;
  assign tx64_st   = tx64_val && (beat_q == 7'd0);
  assign tx64_end  = tx64_val && w_last;
  assign tx64_dwen = tx64_val && w_last && (ur_q || !len_q[0]);
  assign tx64_data = tx64_val ? w_beat_data : 64'd0;
  assign busy      = (state_q != S_IDLE);
  assign drop_cnt  = drop_q;

  assign unused_sink = ^{rx64_end, rx64_data, w_hi_idx, w_lo_idx, w_wr_idx};

endmodule

`default_nettype wire

// File: tb/tb_sfif_mrd_cpl_gen.sv
// Directed bench for sfif_mrd_cpl_gen: MRd requests in, completions checked beat by beat.
`default_nettype none

module tb_sfif_mrd_cpl_gen;

  logic        clk;
  logic        rst;
  logic [15:0] completer_id;
  logic        rx64_st, rx64_end;
  logic [63:0] rx64_data;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic        tx64_req, tx64_rdy, tx64_val, tx64_st, tx64_end, tx64_dwen;
  logic [63:0] tx64_data;
  logic        busy;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  logic [63:0] cap_d    [0:15];
  logic        cap_st   [0:15];
  logic        cap_end  [0:15];
  logic        cap_dwen [0:15];
  int          ncap;

  sfif_mrd_cpl_gen #(.MAX_DW(16), .AW(10)) dut (
    .clk_125(clk), .rst(rst), .completer_id(completer_id),
    .rx64_st(rx64_st), .rx64_end(rx64_end), .rx64_data(rx64_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .tx64_req(tx64_req), .tx64_rdy(tx64_rdy), .tx64_val(tx64_val),
    .tx64_st(tx64_st), .tx64_end(tx64_end), .tx64_dwen(tx64_dwen),
    .tx64_data(tx64_data), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic send_mrd(input logic [9:0] len, input logic [15:0] rid,
                          input logic [7:0] tag, input logic [31:0] addr);
    @(negedge clk);
    rx64_st = 1'b1; rx64_end = 1'b0;
    rx64_data = {8'h00, 14'd0, len, rid, tag, 8'hFF};
    @(negedge clk);
    rx64_st = 1'b0; rx64_end = 1'b1;
    rx64_data = {addr, 32'd0};
    @(negedge clk);
    rx64_end = 1'b0; rx64_data = 64'd0;
  endtask

  // mode 0: rdy held high, 1: rdy toggles 1,0,0,1, 2: rdy high plus a second MRd during FETCH
  task automatic collect(input int mode, input int max_cyc, output int req_first, output int nrd);
    bit          done;
    bit          stalled;
    logic [63:0] held;
    ncap = 0; req_first = -1; nrd = 0; done = 0; stalled = 0; held = '0;
    for (int k = 2; k < max_cyc && !done; k++) begin
      tx64_rdy = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (mode == 2 && k == 4) begin
        rx64_st = 1'b1;
        rx64_data = {8'h00, 14'd0, 10'd2, 16'h0500, 8'h0C, 8'hFF};
      end else if (mode == 2 && k == 5) begin
        rx64_st = 1'b0;
        rx64_data = 64'd0;
      end
      #1;
      if (mem_rd) nrd++;
      if (tx64_req && req_first < 0) req_first = k;
      if (stalled) begin
        checks++;
        if (tx64_val !== 1'b1 || tx64_data !== held) begin
          errors++;
          $display("FAIL stall_hold: got val=%b data=%h required val=1 data=%h", tx64_val, tx64_data, held);
        end
      end
      stalled = tx64_val && !tx64_rdy;
      held = tx64_data;
      if (tx64_val && tx64_rdy) begin
        if (ncap < 16) begin
          cap_d[ncap] = tx64_data; cap_st[ncap] = tx64_st;
          cap_end[ncap] = tx64_end; cap_dwen[ncap] = tx64_dwen;
        end
        ncap++;
        if (tx64_end) done = 1;
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL collect_timeout: got no tx64_end within %0d cycles, required completion", max_cyc);
    end else begin
      #1;
      if (tx64_req !== 1'b0 || tx64_val !== 1'b0) begin
        errors++;
        $display("FAIL req_drop: got req=%b val=%b required 0 0", tx64_req, tx64_val);
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({tx64_req, tx64_val, tx64_st, tx64_end, tx64_dwen, mem_rd, busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 0000000",
               {tx64_req, tx64_val, tx64_st, tx64_end, tx64_dwen, mem_rd, busy});
    end
    checks++;
    if (tx64_data !== 64'd0 || mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%h addr=%h required 0 0", tx64_data, mem_addr);
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop: got %h required 0000", drop_cnt);
    end
  endtask

  task automatic test_single;
    int rf, nrd;
    logic [63:0] exp [0:1];
    exp[0] = {32'h4A00_0001, 16'hABCD, 16'h0004};
    exp[1] = {32'h0100_0510, 32'hCAFE_0001};
    send_mrd(10'd1, 16'h0100, 8'h05, 32'h0000_0010);
    collect(0, 40, rf, nrd);
    checks++;
    if (rf != 4) begin errors++; $display("FAIL single_latency: got %0d required 4", rf); end
    checks++;
    if (nrd != 1) begin errors++; $display("FAIL single_rd: got %0d required 1", nrd); end
    checks++;
    if (ncap != 2) begin errors++; $display("FAIL single_beats: got %0d required 2", ncap); end
    for (int i = 0; i < 2 && i < ncap; i++) begin
      checks++;
      if (cap_d[i] !== exp[i] || cap_st[i] !== (i == 0) || cap_end[i] !== (i == 1)) begin
        errors++;
        $display("FAIL single_beat%0d: got %h st=%b end=%b required %h", i, cap_d[i], cap_st[i], cap_end[i], exp[i]);
      end
    end
    checks++;
    if (ncap >= 2 && cap_dwen[1] !== 1'b0) begin
      errors++; $display("FAIL single_dwen: got %b required 0", cap_dwen[1]);
    end
  endtask

  task automatic test_len4(input int mode);
    int rf, nrd;
    logic [63:0] exp [0:3];
    exp[0] = {32'h4A00_0004, 16'hABCD, 16'h0010};
    exp[1] = {32'h0200_0700, 32'd0};
    exp[2] = {32'd1, 32'd2};
    exp[3] = {32'd3, 32'd0};
    send_mrd(10'd4, 16'h0200, 8'h07, 32'h0000_0000);
    collect(mode, 60, rf, nrd);
    checks++;
    if (rf != 7 || nrd != 4) begin
      errors++; $display("FAIL len4_m%0d_lat_rd: got lat=%0d rd=%0d required 7 4", mode, rf, nrd);
    end
    checks++;
    if (ncap != 4) begin errors++; $display("FAIL len4_m%0d_beats: got %0d required 4", mode, ncap); end
    for (int i = 0; i < 4 && i < ncap; i++) begin
      checks++;
      if (cap_d[i] !== exp[i] || cap_st[i] !== (i == 0) || cap_end[i] !== (i == 3)) begin
        errors++;
        $display("FAIL len4_m%0d_beat%0d: got %h st=%b end=%b required %h", mode, i, cap_d[i], cap_st[i], cap_end[i], exp[i]);
      end
    end
    checks++;
    if (ncap >= 4 && cap_dwen[3] !== 1'b1) begin
      errors++; $display("FAIL len4_m%0d_dwen: got %b required 1", mode, cap_dwen[3]);
    end
  endtask

  task automatic test_ur;
    int rf, nrd;
    logic [63:0] exp [0:1];
    exp[0] = {32'h0A00_0000, 16'hABCD, 16'h2000};
    exp[1] = {32'h0300_0924, 32'd0};
    send_mrd(10'd17, 16'h0300, 8'h09, 32'h0000_0024);
    collect(0, 40, rf, nrd);
    checks++;
    if (nrd != 0) begin errors++; $display("FAIL ur_rd: got %0d required 0", nrd); end
    checks++;
    if (ncap != 2) begin errors++; $display("FAIL ur_beats: got %0d required 2", ncap); end
    for (int i = 0; i < 2 && i < ncap; i++) begin
      checks++;
      if (cap_d[i] !== exp[i] || cap_dwen[i] !== (i == 1) || cap_end[i] !== (i == 1)) begin
        errors++;
        $display("FAIL ur_beat%0d: got %h dwen=%b end=%b required %h", i, cap_d[i], cap_dwen[i], cap_end[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int rf, nrd;
    bit extra;
    logic [63:0] exp [0:5];
    exp[0] = {32'h4A00_0008, 16'hABCD, 16'h0020};
    exp[1] = {32'h0400_0B40, 32'h1000_0000};
    exp[2] = {32'h1000_0001, 32'h1000_0002};
    exp[3] = {32'h1000_0003, 32'h1000_0004};
    exp[4] = {32'h1000_0005, 32'h1000_0006};
    exp[5] = {32'h1000_0007, 32'd0};
    send_mrd(10'd8, 16'h0400, 8'h0B, 32'h0000_0040);
    collect(2, 60, rf, nrd);
    checks++;
    if (nrd != 8 || ncap != 6) begin
      errors++; $display("FAIL b2b_counts: got rd=%0d beats=%0d required 8 6", nrd, ncap);
    end
    for (int i = 0; i < 6 && i < ncap; i++) begin
      checks++;
      if (cap_d[i] !== exp[i]) begin
        errors++; $display("FAIL b2b_beat%0d: got %h required %h", i, cap_d[i], exp[i]);
      end
    end
    checks++;
    if (ncap >= 6 && cap_dwen[5] !== 1'b1) begin
      errors++; $display("FAIL b2b_dwen: got %b required 1", cap_dwen[5]);
    end
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL b2b_drop: got %0d required 1", drop_cnt); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (tx64_req || busy) extra = 1;
    end
    checks++;
    if (extra) begin errors++; $display("FAIL b2b_no_second: got req/busy after drop, required idle"); end
  endtask

  task automatic test_reset_mid;
    int v;
    v = 0;
    tx64_rdy = 1'b1;
    send_mrd(10'd4, 16'h0200, 8'h07, 32'h0000_0000);
    for (int k = 0; k < 30 && v < 2; k++) begin
      #1;
      if (tx64_val) v++;
      if (v < 2) @(negedge clk);
    end
    checks++;
    if (v != 2) begin errors++; $display("FAIL rstmid_reach: got %0d beats required 2", v); end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx64_req, tx64_val, tx64_st, tx64_end, tx64_dwen, mem_rd, busy} !== 7'd0
        || tx64_data !== 64'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got ctl=%b data=%h drop=%h required 0",
               {tx64_req, tx64_val, tx64_st, tx64_end, tx64_dwen, mem_rd, busy}, tx64_data, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    test_single();
  endtask

  initial begin
    rst = 1'b1; completer_id = 16'hABCD;
    rx64_st = 1'b0; rx64_end = 1'b0; rx64_data = 64'd0;
    tx64_rdy = 1'b0; mem_data = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4; i++) mem[i] = i;
    mem[4] = 32'hCAFE_0001;
    for (int i = 0; i < 8; i++) mem[16 + i] = 32'h1000_0000 + i;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_single();
    test_len4(0);
    test_len4(1);
    test_ur();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
